cgp_fitness_eval: RTL and testbench

Synthesizable, sequential replacement for the fixed 2+2-bit adder scoring bench. It sweeps every input vector of an evolved combinational candidate (cgp_module) and compares each output against a parametrised golden function (add, multiply or subtract). It accumulates the bitwise Hamming distance and reports error count, perfect and trivial flags. It sits between the evolution controller, which pulses start, and the candidate circuit; the controller computes the score downstream as 1 - err_count/TOTAL_BITS.

---
 rtl/cgp_eval_pkg.sv | 29 ++
 rtl/cgp_popcount.sv | 17 +
 rtl/cgp_fitness_eval.sv | 140 ++++++++++++++
 tb/tb_cgp_fitness_eval.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cgp_eval_pkg.sv
// Shared constants, FSM state type and golden reference function for the
// CGP fitness evaluator.
package cgp_eval_pkg;

  localparam int unsigned MODE_ADD = 0;
  localparam int unsigned MODE_MUL = 1;
  localparam int unsigned MODE_SUB = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Unsigned golden math at 32 bits; callers truncate to their output width,
  // which also gives the mod 2^OUT_W wrap for subtraction.
  function automatic logic [31:0] golden_result(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input int unsigned mode);
    case (mode)
      MODE_ADD: return a + b;
      MODE_MUL: return a * b;
      MODE_SUB: return a - b;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/cgp_popcount.sv
// Combinational population count of a W-bit vector.
module cgp_popcount #(
  parameter  int unsigned W  = 4,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/cgp_fitness_eval.sv
// Sweeps every input vector of a candidate circuit, compares its outputs to a
// golden function and accumulates the Hamming distance.
module cgp_fitness_eval
  import cgp_eval_pkg::*;
#(
  parameter  int unsigned A_W        = 2,
  parameter  int unsigned B_W        = 2,
  parameter  int unsigned OUT_W      = 4,
  parameter  int unsigned MODE       = 0,
  parameter  int unsigned SETTLE     = 2,
  localparam int unsigned N_IN       = A_W + B_W,
  localparam int unsigned NVEC       = 2 ** N_IN,
  localparam int unsigned TOTAL_BITS = NVEC * OUT_W,
  localparam int unsigned ERR_W      = $clog2(TOTAL_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic             perfect,
  output logic             trivial
);

  localparam int unsigned SC_W = $clog2(SETTLE + 1);
  localparam int unsigned PC_W = $clog2(OUT_W + 1);

  state_t            state, state_nxt;
  logic [N_IN-1:0]   vec;
  logic [SC_W-1:0]   settle;
  logic [OUT_W-1:0]  expected;
  logic [OUT_W-1:0]  miss;
  logic [PC_W-1:0]   miss_cnt;
  logic [ERR_W-1:0]  err_next;
  logic              settle_last;
  logic              vec_last;

  assign dut_in      = vec;
  assign busy        = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign done        = (state == ST_DONE);
  assign settle_last = (settle == SC_W'(SETTLE - 1));
  assign vec_last    = (vec == '1);

  assign expected = OUT_W'(golden_result(32'(vec[A_W-1:0]),
                                         32'(vec[N_IN-1:A_W]), MODE));

  // Case-inequality per bit: an X/Z output bit scores as a mismatch in
  // simulation and reduces to a plain XOR in hardware.
  always_comb begin
    miss = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      miss[i] = (dut_out[i] !== expected[i]);
    end
  end

  cgp_popcount #(.W(OUT_W)) u_popcount (
    .bits  (miss),
    .count (miss_cnt)
  );

  assign err_next = err_count + ERR_W'(miss_cnt);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        if (abort)            state_nxt = ST_IDLE;
        else if (settle_last) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (vec_last) state_nxt = ST_DONE;
        else               state_nxt = ST_DRIVE;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      settle    <= '0;
      err_count <= '0;
      perfect   <= 1'b0;
      trivial   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec       <= '0;
            settle    <= '0;
            err_count <= '0;
            perfect   <= 1'b0;
            trivial   <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            vec       <= '0;
            settle    <= '0;
            err_count <= '0;
          end else if (settle_last) begin
            settle <= '0;
          end else begin
            settle <= settle + SC_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            vec       <= '0;
            settle    <= '0;
            err_count <= '0;
          end else begin
            err_count <= err_next;
            // Flags come from the final sum so they are valid during DONE.
            if (vec_last) begin
              perfect <= (err_next == '0);
              trivial <= (err_next == ERR_W'(TOTAL_BITS / 2));
            end else begin
              vec <= vec + N_IN'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cgp_fitness_eval.sv
// Directed bench for cgp_fitness_eval: default adder instance plus a 3x3
// multiplier instance, each fed by a behavioural candidate circuit.
module tb_cgp_fitness_eval;

  logic       clk;
  logic       rst;
  logic       start1, abort1, start2, abort2;
  logic [3:0] dut_in1, dut_out1;
  logic       busy1, done1, perfect1, trivial1;
  logic [6:0] err1;
  logic [5:0] dut_in2, dut_out2;
  logic       busy2, done2, perfect2, trivial2;
  logic [8:0] err2;
  int         beh;
  int         n_cmp, n_fail;
  int         done_cnt;
  int         cyc, d0;

  cgp_fitness_eval u_dut (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
    .err_count(err1), .perfect(perfect1), .trivial(trivial1)
  );

  cgp_fitness_eval #(.A_W(3), .B_W(3), .OUT_W(6), .MODE(1), .SETTLE(1)) u_mul (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
    .err_count(err2), .perfect(perfect2), .trivial(trivial2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Candidate circuits: bench-side golden adder with selectable faults.
  always_comb begin
    logic [3:0] sum;
    sum = {2'b00, dut_in1[1:0]} + {2'b00, dut_in1[3:2]};
    case (beh)
      0:       dut_out1 = sum;
      1:       dut_out1 = 4'd0;
      2:       dut_out1 = sum ^ 4'b0011;
      3:       dut_out1 = sum ^ 4'b1111;
      default: dut_out1 = sum;
    endcase
  end

  assign dut_out2 = {3'b000, dut_in2[2:0]} * {3'b000, dut_in2[5:3]};

  always @(posedge clk) begin
    if (done1 === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sweep1(output int c);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    c = 1;
    while (done1 !== 1'b1 && c < 300) begin
      tick();
      c++;
    end
  endtask

  task automatic run_to_vec7(output int c);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    c = 0;
    while (dut_in1 !== 4'd7 && c < 100) begin
      tick();
      c++;
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; done_cnt = 0; beh = 0;
    rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_perfect", 32'(perfect1), 0);
    check("rst_trivial", 32'(trivial1), 0);
    check("rst_dut_in", 32'(dut_in1), 0);
    rst = 1'b0;
    tick();

    beh = 0;
    sweep1(cyc);
    check("add_latency", 32'(cyc), 49);
    check("add_busy_in_done", 32'(busy1), 0);
    check("add_err", 32'(err1), 0);
    check("add_perfect", 32'(perfect1), 1);
    check("add_trivial", 32'(trivial1), 0);
    tick();
    check("add_done_pulse", 32'(done1), 0);
    check("add_err_held", 32'(err1), 0);

    beh = 1;
    sweep1(cyc);
    check("zero_err", 32'(err1), 22);
    check("zero_perfect", 32'(perfect1), 0);
    check("zero_trivial", 32'(trivial1), 0);
    tick();

    beh = 2;
    sweep1(cyc);
    check("inv2_err", 32'(err1), 32);
    check("inv2_trivial", 32'(trivial1), 1);
    tick();

    beh = 3;
    sweep1(cyc);
    check("inv4_err", 32'(err1), 64);
    check("inv4_trivial", 32'(trivial1), 0);
    check("inv4_perfect", 32'(perfect1), 0);
    tick();

    // Reset mid-sweep at vector 7; vectors 0..6 of the zero DUT give 8 errors.
    beh = 1;
    run_to_vec7(cyc);
    check("rst_reach7", 32'(dut_in1), 7);
    check("rst_err_at7", 32'(err1), 8);
    check("rst_busy_at7", 32'(busy1), 1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy1), 0);
    check("midrst_dut_in", 32'(dut_in1), 0);
    check("midrst_err", 32'(err1), 0);
    repeat (60) tick();
    check("midrst_no_done", 32'(done_cnt), 32'(d0));

    run_to_vec7(cyc);
    check("abort_reach7", 32'(dut_in1), 7);
    d0 = done_cnt;
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("abort_busy", 32'(busy1), 0);
    check("abort_dut_in", 32'(dut_in1), 0);
    check("abort_err", 32'(err1), 0);
    repeat (60) tick();
    check("abort_no_done", 32'(done_cnt), 32'(d0));

    beh = 0;
    sweep1(cyc);
    check("after_abort_latency", 32'(cyc), 49);
    check("after_abort_err", 32'(err1), 0);
    check("after_abort_perfect", 32'(perfect1), 1);
    tick();

    // start re-pulsed mid-sweep and in DONE must not disturb the sweep.
    beh = 1;
    d0 = done_cnt;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 300) begin
      start1 = (cyc == 10 || cyc == 20);
      tick();
      cyc++;
    end
    check("restart_latency", 32'(cyc), 49);
    check("restart_err", 32'(err1), 22);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("start_in_done_busy", 32'(busy1), 0);
    check("start_in_done_done", 32'(done1), 0);
    repeat (10) tick();
    check("restart_err_held", 32'(err1), 22);
    check("restart_busy_idle", 32'(busy1), 0);
    check("restart_one_done", 32'(done_cnt), 32'(d0 + 1));

    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 1;
    while (done2 !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("mul_latency", 32'(cyc), 129);
    check("mul_err", 32'(err2), 0);
    check("mul_perfect", 32'(perfect2), 1);
    check("mul_trivial", 32'(trivial2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
